// File: rtl/i2c_pad_filter_if.sv
// I2C pad filter bus bundle.
// Groups the raw pad inputs, the filter CSR inputs and every conditioned
// output of i2c_pad_filter so the block can be bound with one port.
//   master : drives pads, filter threshold and glitch clear; observes outputs
//   slave  : the filter itself (consumes pads/CSRs, drives filtered outputs)
// There is no valid/ready handshake here: every output is a level or a
// single-cycle pulse in the clk_i domain, and inputs are sampled each cycle.
interface i2c_pad_filter_if #(
  parameter int FiltCntW   = 4,
  parameter int GlitchCntW = 16
);
  logic                  scl_pad_i;
  logic                  sda_pad_i;
  logic [FiltCntW-1:0]   filt_cycles_i;
  logic                  glitch_clr_i;
  logic                  scl_o;
  logic                  sda_o;
  logic                  scl_rise_o;
  logic                  scl_fall_o;
  logic                  sda_rise_o;
  logic                  sda_fall_o;
  logic                  start_det_o;
  logic                  stop_det_o;
  logic                  bus_busy_o;
  logic [GlitchCntW-1:0] glitch_cnt_o;

  modport master (
    output scl_pad_i, sda_pad_i, filt_cycles_i, glitch_clr_i,
    input  scl_o, sda_o, scl_rise_o, scl_fall_o, sda_rise_o, sda_fall_o,
           start_det_o, stop_det_o, bus_busy_o, glitch_cnt_o
  );

  modport slave (
    input  scl_pad_i, sda_pad_i, filt_cycles_i, glitch_clr_i,
    output scl_o, sda_o, scl_rise_o, scl_fall_o, sda_rise_o, sda_fall_o,
           start_det_o, stop_det_o, bus_busy_o, glitch_cnt_o
  );
endinterface

// File: rtl/i2c_pad_filter.sv
// I2C pad input conditioning.
// Synchronises SCL/SDA into clk_i, rejects pulses shorter than
// filt_cycles_i+1 synced cycles, and derives edge/START/STOP pulses, a
// bus-busy flag and a saturating glitch counter from the filtered levels.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : pads, filter threshold, glitch clear in; filtered levels,
//                  edge pulses, start/stop pulses, busy, glitch count out
// bus_busy_o is the bus-tracking FSM state (IDLE=0, BUSY=1).
module i2c_pad_filter #(
  parameter int SyncStages = 2,
  parameter int FiltCntW   = 4,
  parameter int GlitchCntW = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  i2c_pad_filter_if.slave bus
);

  localparam int GW1 = GlitchCntW + 1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_e;

  // Index 0 is SCL, index 1 is SDA throughout.
  logic [1:0]                 pad;
  logic [1:0][SyncStages-1:0] sync_q;
  logic [1:0]                 s;
  logic [1:0]                 f_q, f_d;
  logic [1:0][FiltCntW-1:0]   c_q, c_d;
  logic [1:0]                 rise_q, rise_d;
  logic [1:0]                 fall_q, fall_d;
  logic [1:0]                 abort;
  logic [GlitchCntW-1:0]      gcnt_q, gcnt_d;
  logic [GW1-1:0]             gsum;
  logic                       start_det, stop_det;
  bus_state_e                 state_q, state_d;

  assign pad = {bus.sda_pad_i, bus.scl_pad_i};

  // Synchronisers reset to 1 so release of reset never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SyncStages-2:0], pad[i]};
      end
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < 2; i++) begin
      s[i] = sync_q[i][SyncStages-1];
    end
  end

  // Filter: a new level is taken once the counter has reached the threshold
  // while still differing. Comparing with >= lets a lowered threshold apply
  // mid-count; the counter can never pass the threshold, so it cannot wrap.
  always_comb begin
    f_d    = f_q;
    c_d    = c_q;
    rise_d = '0;
    fall_d = '0;
    abort  = '0;
    for (int i = 0; i < 2; i++) begin
      if (s[i] == f_q[i]) begin
        c_d[i]   = '0;
        abort[i] = (c_q[i] != '0);
      end else if (c_q[i] >= bus.filt_cycles_i) begin
        f_d[i]    = s[i];
        c_d[i]    = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        c_d[i] = c_q[i] + FiltCntW'(1);
      end
    end
  end

  // Glitch counter: widened sum so saturation is a single carry test.
  always_comb begin
    gsum = {1'b0, gcnt_q} + GW1'(abort[0]) + GW1'(abort[1]);
    if (bus.glitch_clr_i) begin
      gcnt_d = '0;
    end else if (gsum[GlitchCntW]) begin
      gcnt_d = '1;
    end else begin
      gcnt_d = gsum[GlitchCntW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_q    <= 2'b11;
      c_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      gcnt_q <= '0;
    end else begin
      f_q    <= f_d;
      c_q    <= c_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      gcnt_q <= gcnt_d;
    end
  end

  // A simultaneous SCL edge makes the SDA edge ambiguous, so it is ignored.
  assign start_det = fall_q[1] & f_q[0] & ~rise_q[0] & ~fall_q[0];
  assign stop_det  = rise_q[1] & f_q[0] & ~rise_q[0] & ~fall_q[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = BUS_BUSY;
    end else if (stop_det) begin
      state_d = BUS_IDLE;
    end
  end

  assign bus.scl_o        = f_q[0];
  assign bus.sda_o        = f_q[1];
  assign bus.scl_rise_o   = rise_q[0];
  assign bus.scl_fall_o   = fall_q[0];
  assign bus.sda_rise_o   = rise_q[1];
  assign bus.sda_fall_o   = fall_q[1];
  assign bus.start_det_o  = start_det;
  assign bus.stop_det_o   = stop_det;
  assign bus.bus_busy_o   = (state_q == BUS_BUSY);
  assign bus.glitch_cnt_o = gcnt_q;

endmodule

// File: tb/tb_i2c_pad_filter.sv
// Bench for i2c_pad_filter: a history-window reference model predicts every
// output each cycle; scenario tasks add targeted latency and pulse checks.
module tb_i2c_pad_filter;
  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int GW   = 16;
  localparam int HL   = SYNC + 17;
  localparam int VW   = GW + 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_pad_filter_if #(.FiltCntW(FW), .GlitchCntW(GW)) bus ();

  i2c_pad_filter #(.SyncStages(SYNC), .FiltCntW(FW), .GlitchCntW(GW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw pad history per line (index 0 newest), filtered
  // levels and predicted outputs after the most recent clock edge.
  bit            ph [2][HL];
  bit            m_f [2];
  bit            m_rise [2];
  bit            m_fall [2];
  bit            m_start, m_stop, m_busy;
  logic [GW-1:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < HL; k++) ph[i][k] = 1'b1;
      m_f[i] = 1'b1; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
    end
    m_start = 1'b0; m_stop = 1'b0; m_busy = 1'b0; m_cnt = '0;
  endtask

  // One clock edge: a level is accepted when the last N+1 synced samples all
  // differ from the current level; a glitch is a return to the current level
  // right after a differing sample.
  task automatic model_step();
    int  n;
    int  inc;
    bit  s, acc, gl, pv;
    n = int'(bus.filt_cycles_i);
    if (m_start) m_busy = 1'b1;
    else if (m_stop) m_busy = 1'b0;
    inc = 0;
    for (int i = 0; i < 2; i++) begin
      pv = (i == 0) ? bus.scl_pad_i : bus.sda_pad_i;
      for (int k = HL - 1; k > 0; k--) ph[i][k] = ph[i][k-1];
      ph[i][0] = pv;
      s   = ph[i][SYNC];
      acc = (s != m_f[i]);
      for (int j = 0; j <= n; j++) if (ph[i][SYNC+j] != s) acc = 1'b0;
      gl = (s == m_f[i]) && (ph[i][SYNC+1] != m_f[i]);
      m_rise[i] = acc && s;
      m_fall[i] = acc && !s;
      if (acc) m_f[i] = s;
      if (gl) inc++;
    end
    m_start = m_fall[1] && m_f[0] && !m_rise[0] && !m_fall[0];
    m_stop  = m_rise[1] && m_f[0] && !m_rise[0] && !m_fall[0];
    if (bus.glitch_clr_i) m_cnt = '0;
    else if (longint'(m_cnt) + inc >= (longint'(1) << GW)) m_cnt = '1;
    else m_cnt = m_cnt + GW'(inc);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  function automatic logic [VW-1:0] obs();
    return {bus.scl_o, bus.sda_o, bus.scl_rise_o, bus.scl_fall_o,
            bus.sda_rise_o, bus.sda_fall_o, bus.start_det_o, bus.stop_det_o,
            bus.bus_busy_o, bus.glitch_cnt_o};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {m_f[0], m_f[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1],
            m_start, m_stop, m_busy, m_cnt};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.scl_pad_i = 1'b1; bus.sda_pad_i = 1'b1;
    bus.filt_cycles_i = '0; bus.glitch_clr_i = 1'b0;
    model_reset();
    repeat (3) cycle();
    n_checks++;
    if (obs() !== {9'b110000000, 16'h0}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs(), {9'b110000000, 16'h0});
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_checks++;
      if (obs() !== expv() || obs() !== {9'b110000000, 16'h0}) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_glitch_n3();
    int first, pulses;
    bus.filt_cycles_i = 4'd3;
    bus.sda_pad_i = 1'b0;
    repeat (3) cycle();
    bus.sda_pad_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL glitch3 cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if (bus.sda_o !== 1'b1 || bus.glitch_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL glitch3_count: got sda %b cnt %0d want sda 1 cnt 1", bus.sda_o, bus.glitch_cnt_o);
    end
    bus.sda_pad_i = 1'b0;
    first = -1; pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) bus.sda_pad_i = 1'b1;
      cycle();
      if (bus.sda_fall_o === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL accept4 cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if (first != 6 || pulses != 1) begin
      n_fail++; $display("FAIL accept4_latency: got first %0d pulses %0d want first 6 pulses 1", first, pulses);
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL glitch3_settle cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_start_stop();
    int starts, stops, busy_after;
    bus.filt_cycles_i = '0;
    repeat (4) cycle();
    bus.sda_pad_i = 1'b0;
    starts = 0; busy_after = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (starts == 1 && busy_after < 0) busy_after = int'(bus.bus_busy_o);
      if (bus.start_det_o === 1'b1) starts++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL start cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if (starts != 1 || busy_after != 1) begin
      n_fail++; $display("FAIL start_pulse: got starts %0d busy %0d want 1 1", starts, busy_after);
    end
    bus.sda_pad_i = 1'b1;
    stops = 0; busy_after = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (stops == 1 && busy_after < 0) busy_after = int'(bus.bus_busy_o);
      if (bus.stop_det_o === 1'b1) stops++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL stop cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if (stops != 1 || busy_after != 0) begin
      n_fail++; $display("FAIL stop_pulse: got stops %0d busy %0d want 1 0", stops, busy_after);
    end
  endtask

  task automatic test_simultaneous();
    int both, starts, stops;
    bus.filt_cycles_i = '0;
    both = 0; starts = 0; stops = 0;
    bus.scl_pad_i = 1'b0; bus.sda_pad_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) begin bus.scl_pad_i = 1'b1; bus.sda_pad_i = 1'b1; end
      cycle();
      if (bus.scl_fall_o === 1'b1 && bus.sda_fall_o === 1'b1) both++;
      if (bus.start_det_o === 1'b1) starts++;
      if (bus.stop_det_o === 1'b1) stops++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL simul cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if (both != 1 || starts != 0 || stops != 0 || bus.bus_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL simul_ambiguous: got both %0d start %0d stop %0d busy %b want 1 0 0 0",
                         both, starts, stops, bus.bus_busy_o);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 60; seg++) begin
      bus.filt_cycles_i = FW'($urandom_range(0, 5));
      for (int t = 0; t < 30; t += hold) begin
        hold = $urandom_range(1, 6);
        bus.scl_pad_i = 1'($urandom_range(0, 1));
        bus.sda_pad_i = 1'($urandom_range(0, 1));
        for (int h = 0; h < hold; h++) begin
          bus.glitch_clr_i = ($urandom_range(0, 39) == 0);
          cycle();
          n_checks++;
          if (obs() !== expv()) begin
            n_fail++; $display("FAIL random seg %0d: got %h want %h", seg, obs(), expv());
          end
        end
      end
    end
    bus.glitch_clr_i = 1'b0;
    bus.scl_pad_i = 1'b1; bus.sda_pad_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random_settle cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_glitch_sat();
    bus.filt_cycles_i = 4'd1;
    bus.glitch_clr_i = 1'b1;
    cycle();
    bus.glitch_clr_i = 1'b0;
    for (int k = 0; k < 70000 && m_cnt != '1; k++) begin
      bus.scl_pad_i = k[0]; bus.sda_pad_i = k[0];
      cycle();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL sat_ramp cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    bus.scl_pad_i = 1'b1; bus.sda_pad_i = 1'b1;
    repeat (6) cycle();
    bus.scl_pad_i = 1'b0; bus.sda_pad_i = 1'b0;
    cycle();
    bus.scl_pad_i = 1'b1; bus.sda_pad_i = 1'b1;
    repeat (5) cycle();
    n_checks++;
    if (bus.glitch_cnt_o !== 16'hFFFF || obs() !== expv()) begin
      n_fail++; $display("FAIL sat_hold: got %h want cnt ffff model %h", obs(), expv());
    end
    bus.scl_pad_i = 1'b0;
    cycle();
    bus.scl_pad_i = 1'b1;
    cycle();
    cycle();
    bus.glitch_clr_i = 1'b1;
    cycle();
    bus.glitch_clr_i = 1'b0;
    n_checks++;
    if (bus.glitch_cnt_o !== 16'h0 || obs() !== expv()) begin
      n_fail++; $display("FAIL clr_priority: got %h want cnt 0 model %h", obs(), expv());
    end
  endtask

  task automatic test_reset_midcount();
    int first;
    bus.filt_cycles_i = 4'd15;
    bus.scl_pad_i = 1'b1; bus.sda_pad_i = 1'b1;
    repeat (20) cycle();
    bus.sda_pad_i = 1'b0;
    repeat (8) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== {9'b110000000, 16'h0}) begin
      n_fail++; $display("FAIL midrst_assert: got %h want %h", obs(), {9'b110000000, 16'h0});
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (bus.bus_busy_o !== 1'b0 || obs() !== expv()) begin
        n_fail++; $display("FAIL midrst_hold cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    rst = 1'b0;
    first = -1;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      if (bus.sda_fall_o === 1'b1 && first < 0) first = k;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL midrst_release cyc %0d: got %h want %h", k, obs(), expv());
      end
    end
    n_checks++;
    if (first != SYNC + 16) begin
      n_fail++; $display("FAIL midrst_latency: got %0d want %0d", first, SYNC + 16);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_n3();
    test_start_stop();
    test_simultaneous();
    test_random();
    test_glitch_sat();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_pad_filter.md
Name: i2c_pad_filter

Overview:
- Input conditioning stage between the I2C SCL/SDA pads and the I2C controller's cio_scl_i/cio_sda_i inputs.
- Synchronises both pad inputs into clk_i and removes glitches shorter than a programmable number of cycles.
- Produces filtered line levels plus single-cycle edge, START and STOP pulses, a bus-busy flag, and a saturating glitch counter for diagnostics.

Parameters:
SyncStages, 2, number of synchroniser flops per line (legal 2..4)
FiltCntW, 4, width of the filter threshold and per-line stability counter
GlitchCntW, 16, width of the glitch event counter

Ports:
clk_i  input  1  single clock for the whole block
rst_i  input  1  reset, asynchronous assert, active-high
scl_pad_i  input  1  raw SCL from pad, asynchronous
sda_pad_i  input  1  raw SDA from pad, asynchronous
filt_cycles_i  input  FiltCntW  filter threshold N, quasi-static CSR value
glitch_clr_i  input  1  single-cycle clear of glitch_cnt_o
scl_o  output  1  filtered SCL, drives controller cio_scl_i
sda_o  output  1  filtered SDA, drives controller cio_sda_i
scl_rise_o  output  1  pulse: scl_o went 0->1
scl_fall_o  output  1  pulse: scl_o went 1->0
sda_rise_o  output  1  pulse: sda_o went 0->1
sda_fall_o  output  1  pulse: sda_o went 1->0
start_det_o  output  1  pulse: START or repeated START detected
stop_det_o  output  1  pulse: STOP detected
bus_busy_o  output  1  high between START and STOP
glitch_cnt_o  output  GlitchCntW  count of rejected glitches, saturating

Behaviour:
- Reset values, applied asynchronously on rst_i high:
  - Synchroniser flops, scl_o and sda_o = 1 (idle bus).
  - Stability counters = 0; glitch_cnt_o = 0.
  - All pulses and bus_busy_o = 0.
- Synchroniser: SyncStages flops per line. The synced value s lags the pad by SyncStages cycles.
- Per-line filter, with registered filtered value f and counter c:
  - s == f: c <= 0. If c != 0 in that cycle (a run was aborted), it counts as one glitch.
  - s != f and c >= N: f <= s, c <= 0, and the matching edge pulse is asserted in the same cycle f changes.
  - s != f and c < N: c <= c + 1. c never exceeds 2^FiltCntW-1.
  - A level is accepted after N+1 consecutive differing synced cycles. Pad-to-output latency = SyncStages + N + 1 cycles.
  - N = 0 means no filtering: latency is SyncStages + 1 and no glitches are ever counted.
  - Using >= makes a lowered N take effect immediately, mid-count.
- Edge pulses are registered and high for exactly one cycle, in the first cycle the output shows the new level.
- START/STOP detection uses the filtered levels:
  - start_det_o = sda_fall with scl_o == 1 and no scl edge in the same cycle.
  - stop_det_o = sda_rise with scl_o == 1 and no scl edge in the same cycle.
  - If SCL and SDA change in the same cycle, the event is ambiguous and neither pulse fires.
- bus_busy_o:
  - Set on the cycle after start_det_o; cleared on the cycle after stop_det_o.
  - A repeated START while busy pulses start_det_o and leaves busy at 1.
  - A STOP while idle pulses stop_det_o and leaves busy at 0.
- glitch_cnt_o:
  - Increments by the number of lines (0, 1 or 2) that abort a run in a cycle.
  - Saturates at all-ones and never wraps.
  - glitch_clr_i has priority: the counter becomes 0 and same-cycle increments are discarded.
- Reset mid-operation, including mid-count: everything returns to the reset values above. No pulse is generated on reset release even if the pads are low; the first falling edge is reported SyncStages+N+1 cycles after release.

Test Plan:
- Reset with pads held 1, then release -> scl_o = sda_o = 1, bus_busy_o = 0, glitch_cnt_o = 0, no pulses for 20 cycles.
- N = 3: drive SDA low for 3 cycles, then high -> sda_o stays 1, glitch_cnt_o = 1. Drive SDA low for 4 cycles -> sda_fall_o pulses exactly once, SyncStages+4 = 6 cycles after the pad edge.
- N = 0, SCL high, drop SDA -> start_det_o one pulse, bus_busy_o = 1 next cycle. Raise SDA -> stop_det_o one pulse, bus_busy_o = 0.
- N = 0, SCL and SDA falling on the same pad cycle -> scl_fall_o and sda_fall_o both pulse, start_det_o stays 0.
- Glitch counter: 65535 prior glitches, then simultaneous SCL+SDA glitch -> holds 0xFFFF. Assert glitch_clr_i together with a new glitch -> 0.
- N = 15: assert rst_i mid-count with SDA low at the pad, then release -> no pulse at release; sda_fall_o fires 18 cycles after release; bus_busy_o was 0 throughout reset.
